// File: rtl/accumulator_16b.sv
// Sequential 16-bit accumulator: sums a run of 1..16 unsigned operands through a
// valid/ready stream and presents the wrapped sum plus a sticky carry flag.
module rippleAdder16b (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic [15:0] sum,
   output logic        c_out
);

   logic [16:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = c_in;
      for (int i = 0; i < 16; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
      c_out = c[16];
   end

endmodule

module accumulator_16b (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        start,
   input  logic [3:0]  len,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] sum_out,
   output logic        carry_flag,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] acc;
   logic [4:0]  cnt;
   logic [4:0]  n;
   logic [15:0] add_sum;
   logic        add_c;
   logic        take;
   logic        last;
   logic        start_ok;

   rippleAdder16b u_add (
      .a     (acc),
      .b     (in_data),
      .c_in  (1'b0),
      .sum   (add_sum),
      .c_out (add_c)
   );

   assign last     = (cnt + 5'd1) == n;
   assign start_ok = (state == IDLE) && start && !clear;
   assign sum_out  = acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      take       = 1'b0;
      case (state)
         IDLE: if (start) state_next = ACC;
         ACC: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            take     = in_valid;
            if (in_valid && last) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // clear overrides every transition, including a start seen in IDLE
      if (clear) begin
         state_next = IDLE;
         take       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         cnt        <= '0;
         n          <= 5'd16;
         carry_flag <= 1'b0;
      end else if (clear) begin
         acc        <= '0;
         cnt        <= '0;
         carry_flag <= 1'b0;
      end else if (start_ok) begin
         n          <= (len == 4'd0) ? 5'd16 : {1'b0, len};
         acc        <= '0;
         cnt        <= '0;
         carry_flag <= 1'b0;
      end else if (take) begin
         acc        <= add_sum;
         carry_flag <= carry_flag | add_c;
         cnt        <= cnt + 5'd1;
      end
   end

endmodule

// File: tb/tb_accumulator_16b.sv
// Bench for accumulator_16b: table-driven runs, directed corner sequences and a
// randomized phase compared against a run-level arithmetic model.
module tb_accumulator_16b;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        start;
   logic [3:0]  len;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum_out;
   logic        carry_flag;
   logic        busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [3:0]        len;
      logic [15:0][15:0] ops;
      logic [15:0]       exp_sum;
      logic              exp_carry;
   } vec_t;

   vec_t tbl [6];

   accumulator_16b dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .start      (start),
      .len        (len),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sum_out    (sum_out),
      .carry_flag (carry_flag),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int n;
      n = (v.len == 4'd0) ? 16 : int'(v.len);
      start = 1'b1;
      len   = v.len;
      tick;
      start = 1'b0;
      chk({name, "_busy"}, 32'(busy), 32'd1);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = v.ops[i];
         chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
         chk({name, "_no_early_valid"}, 32'(out_valid), 32'd0);
         tick;
      end
      in_valid = 1'b0;
      chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
      chk({name, "_sum"}, 32'(sum_out), 32'(v.exp_sum));
      chk({name, "_carry"}, 32'(carry_flag), 32'(v.exp_carry));
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk({name, "_idle_busy"}, 32'(busy), 32'd0);
      chk({name, "_idle_out_valid"}, 32'(out_valid), 32'd0);
      chk({name, "_sum_held"}, 32'(sum_out), 32'(v.exp_sum));
   endtask

   initial begin
      int accepted;
      bit m_active, m_result, m_carry;
      int m_left;
      int unsigned m_total;

      rst = 1'b1; clear = 1'b0; start = 1'b0; len = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      tbl[0].len = 4'd3;  tbl[0].ops = '0;
      tbl[0].ops[0] = 16'h0001; tbl[0].ops[1] = 16'h0002; tbl[0].ops[2] = 16'h0003;
      tbl[0].exp_sum = 16'h0006; tbl[0].exp_carry = 1'b0;
      tbl[1].len = 4'd2;  tbl[1].ops = '0;
      tbl[1].ops[0] = 16'hFFFF; tbl[1].ops[1] = 16'h0002;
      tbl[1].exp_sum = 16'h0001; tbl[1].exp_carry = 1'b1;
      tbl[2].len = 4'd1;  tbl[2].ops = '0;
      tbl[2].ops[0] = 16'h00AA;
      tbl[2].exp_sum = 16'h00AA; tbl[2].exp_carry = 1'b0;
      tbl[3].len = 4'd0;
      for (int i = 0; i < 16; i++) tbl[3].ops[i] = 16'h1000;
      tbl[3].exp_sum = 16'h0000; tbl[3].exp_carry = 1'b1;
      tbl[4].len = 4'd4;  tbl[4].ops = '0;
      tbl[4].ops[0] = 16'h8000; tbl[4].ops[1] = 16'h8000;
      tbl[4].ops[2] = 16'h0001; tbl[4].ops[3] = 16'h0001;
      tbl[4].exp_sum = 16'h0002; tbl[4].exp_carry = 1'b1;
      tbl[5].len = 4'd15;
      for (int i = 0; i < 16; i++) tbl[5].ops[i] = 16'h1111;
      tbl[5].exp_sum = 16'hFFFF; tbl[5].exp_carry = 1'b0;

      // reset state
      tick;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum_out), 32'd0);
      chk("rst_carry", 32'(carry_flag), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick;

      for (int t = 0; t < 6; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

      // start and clear together in IDLE: start discarded
      start = 1'b1; clear = 1'b1; len = 4'd3;
      tick;
      start = 1'b0; clear = 1'b0;
      chk("start_clear_busy", 32'(busy), 32'd0);
      chk("start_clear_sum", 32'(sum_out), 32'd0);
      tick;
      chk("start_clear_busy2", 32'(busy), 32'd0);

      // backpressure and input gaps
      start = 1'b1; len = 4'd4;
      tick;
      start = 1'b0;
      accepted = 0;
      for (int k = 0; k < 20 && !out_valid; k++) begin
         in_valid = (k % 2 == 0);
         in_data  = in_valid ? 16'(16'h0100 + k) : 16'hFFFF;
         if (in_valid && in_ready) accepted++;
         tick;
      end
      chk("bp_accepted", 32'(accepted), 32'd4);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b1; in_data = 16'h7777; out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("bp_sum_stable", 32'(sum_out), 32'h040C);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_no_ready", 32'(in_ready), 32'd0);
         tick;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("bp_idle", 32'(busy), 32'd0);
      chk("bp_sum_after", 32'(sum_out), 32'h040C);

      // clear after the 2nd accept of a len=5 run
      start = 1'b1; len = 4'd5;
      tick;
      start = 1'b0;
      in_valid = 1'b1; in_data = 16'hFFFF;
      tick;
      in_data = 16'h0002;
      tick;
      chk("clr_pre_sum", 32'(sum_out), 32'h0001);
      chk("clr_pre_carry", 32'(carry_flag), 32'd1);
      clear = 1'b1; in_data = 16'h0003;
      tick;
      clear = 1'b0; in_data = 16'h0004;
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_sum", 32'(sum_out), 32'd0);
      chk("clr_carry", 32'(carry_flag), 32'd0);
      chk("clr_in_ready", 32'(in_ready), 32'd0);
      tick;
      in_valid = 1'b0;
      chk("clr_no_accept", 32'(sum_out), 32'd0);
      chk("clr_still_idle", 32'(busy), 32'd0);

      // asynchronous reset pulse while in DONE
      start = 1'b1; len = 4'd1;
      tick;
      start = 1'b0; in_valid = 1'b1; in_data = 16'h0005;
      tick;
      in_valid = 1'b0;
      chk("arst_done", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_sum", 32'(sum_out), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      #1 rst = 1'b0;
      tick;
      chk("arst_idle_after", 32'(busy), 32'd0);
      run_vec(tbl[2], "arst_rerun");

      // randomized phase against a run-level model
      clear = 1'b1;
      tick;
      clear = 1'b0;
      m_active = 0; m_result = 0; m_carry = 0; m_total = 0; m_left = 0;
      for (int k = 0; k < 600; k++) begin
         chk("rnd_in_ready", 32'(in_ready), 32'(m_active && !m_result));
         chk("rnd_out_valid", 32'(out_valid), 32'(m_result));
         chk("rnd_busy", 32'(busy), 32'(m_active));
         chk("rnd_sum", 32'(sum_out), m_total & 32'hFFFF);
         chk("rnd_carry", 32'(carry_flag), 32'(m_carry));
         clear     = ($urandom_range(0, 39) == 0);
         start     = ($urandom_range(0, 3) == 0);
         len       = 4'($urandom);
         in_valid  = 1'($urandom);
         in_data   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         out_ready = ($urandom_range(0, 2) == 0);
         if (clear) begin
            m_active = 0; m_result = 0; m_total = 0; m_carry = 0;
         end else if (!m_active) begin
            if (start) begin
               m_active = 1; m_result = 0; m_total = 0; m_carry = 0;
               m_left = (len == 4'd0) ? 16 : int'(len);
            end
         end else if (!m_result) begin
            if (in_valid) begin
               if (m_total + in_data > 32'hFFFF) m_carry = 1;
               m_total = (m_total + in_data) & 32'hFFFF;
               m_left--;
               if (m_left == 0) m_result = 1;
            end
         end else if (out_ready) begin
            m_active = 0; m_result = 0;
         end
         tick;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
